// File: rtl/alu_decode_stage.sv
// Registered, handshaked ALU control decoder for the RV32 datapath.
// Define RV_M_EXT_EN to decode RV32M ops with programmable multi-cycle latency.
module alu_decode_stage #(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              opb5,
    input  logic              funct7b5,
    input  logic              funct7b0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              multicycle,
    output logic              illegal,
    output logic              busy
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLT  = 5'b00101;
    localparam logic [4:0] OP_SLTU = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b00111;
    localparam logic [4:0] OP_SRL  = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_VALID = 2'd2;
`ifdef RV_M_EXT_EN
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [7:0] MUL_CNT  = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_CNT  = 8'(DIV_LAT - 1);
`endif

    if (CTRL_W < 5 || MUL_LAT < 1 || MUL_LAT > 255 || DIV_LAT < 1 || DIV_LAT > 255) begin : g_param_err
        $error("alu_decode_stage: CTRL_W must be >= 5 and latencies must be 1..255");
    end

    logic [1:0]        state_reg;
    logic              out_valid_reg;
    logic [CTRL_W-1:0] alu_control_reg;
    logic              illegal_reg;
    logic [4:0]        dec_code;
    logic              dec_ill;
    logic              dec_mreq;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              accept;

    // Combinational decode of the offered instruction; captured only on accept.
    always_comb begin
        dec_code = OP_ADD;
        dec_ill  = 1'b0;
        dec_mreq = 1'b0;
        case (alu_op)
            2'b00: dec_code = OP_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: dec_code = OP_SUB;
                    3'b100, 3'b101: dec_code = OP_SLT;
                    3'b110, 3'b111: dec_code = OP_SLTU;
                    default: begin
                        dec_code = OP_SUB;
                        dec_ill  = 1'b1;
                    end
                endcase
            end
            2'b10: begin
                if (opb5 && funct7b0) begin
                    dec_mreq = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  dec_code = (opb5 && funct7b5) ? OP_SUB : OP_ADD;
                        3'b001:  dec_code = OP_SLL;
                        3'b010:  dec_code = OP_SLT;
                        3'b011:  dec_code = OP_SLTU;
                        3'b100:  dec_code = OP_XOR;
                        3'b101:  dec_code = funct7b5 ? OP_SRA : OP_SRL;
                        3'b110:  dec_code = OP_OR;
                        default: dec_code = OP_AND;
                    endcase
                end
            end
            default: dec_ill = 1'b1;
        endcase
`ifdef RV_M_EXT_EN
        if (dec_mreq) begin
            dec_code = {2'b10, funct3};
        end
`else
        if (dec_mreq) begin
            dec_code = OP_ADD;
            dec_ill  = 1'b1;
        end
`endif
        dec_ctrl      = '0;
        dec_ctrl[4:0] = dec_code;
    end

    assign in_ready    = rst_n & ((state_reg == ST_IDLE) | ((state_reg == ST_VALID) & out_ready));
    assign accept      = in_valid & in_ready;
    assign out_valid   = out_valid_reg;
    assign alu_control = alu_control_reg;
    assign illegal     = illegal_reg;

`ifdef RV_M_EXT_EN
    logic [7:0] cnt_reg;
    logic       multicycle_reg;
    logic [7:0] lat_cnt;
    logic       go_wait;

    assign lat_cnt    = funct3[2] ? DIV_CNT : MUL_CNT;
    assign go_wait    = dec_mreq && (lat_cnt != 8'd0);
    assign multicycle = multicycle_reg;
    assign busy       = (state_reg == ST_WAIT);
`else
    assign multicycle = 1'b0;
    assign busy       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            out_valid_reg   <= 1'b0;
            alu_control_reg <= '0;
            illegal_reg     <= 1'b0;
`ifdef RV_M_EXT_EN
            cnt_reg         <= 8'd0;
            multicycle_reg  <= 1'b0;
`endif
        end else if (accept) begin
            alu_control_reg <= dec_ctrl;
            illegal_reg     <= dec_ill;
`ifdef RV_M_EXT_EN
            multicycle_reg  <= dec_mreq;
            if (go_wait) begin
                state_reg     <= ST_WAIT;
                cnt_reg       <= lat_cnt;
                out_valid_reg <= 1'b0;
            end else begin
                state_reg     <= ST_VALID;
                out_valid_reg <= 1'b1;
            end
`else
            state_reg       <= ST_VALID;
            out_valid_reg   <= 1'b1;
`endif
        end else begin
            case (state_reg)
`ifdef RV_M_EXT_EN
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 8'd1;
                    if (cnt_reg == 8'd1) begin
                        state_reg     <= ST_VALID;
                        out_valid_reg <= 1'b1;
                    end
                end
`endif
                ST_VALID: begin
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: transaction-level model plus directed vectors.
// Honours RV_M_EXT_EN the same way the design does.
module tb_alu_decode_stage;

    localparam int CTRL_W  = 5;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        alu_op = 2'b00;
    logic [2:0]        funct3 = 3'b000;
    logic              opb5 = 1'b0;
    logic              funct7b5 = 1'b0;
    logic              funct7b0 = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] alu_control;
    logic              multicycle;
    logic              illegal;
    logic              busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_decode_stage #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .opb5(opb5), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .multicycle(multicycle), .illegal(illegal),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction table: {illegal, m_op, code[4:0]}.
    function automatic logic [6:0] ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                           input logic b5, input logic f75, input logic f70);
        logic [4:0] code;
        logic       ill;
        logic       m;
        code = 5'd0; ill = 1'b0; m = 1'b0;
        if (op == 2'b00) begin
            code = 5'd0;
        end else if (op == 2'b01) begin
            if (f3 == 3'b010 || f3 == 3'b011) begin code = 5'd1; ill = 1'b1; end
            else if (f3[2:1] == 2'b00) code = 5'd1;
            else if (f3[2:1] == 2'b10) code = 5'd5;
            else code = 5'd6;
        end else if (op == 2'b10) begin
            if (b5 && f70) begin
`ifdef RV_M_EXT_EN
                m = 1'b1;
                code = 5'd16 + {2'b00, f3};
`else
                ill = 1'b1;
`endif
            end else begin
                unique case (f3)
                    3'd0: code = (b5 && f75) ? 5'd1 : 5'd0;
                    3'd1: code = 5'd7;
                    3'd2: code = 5'd5;
                    3'd3: code = 5'd6;
                    3'd4: code = 5'd4;
                    3'd5: code = f75 ? 5'd9 : 5'd8;
                    3'd6: code = 5'd3;
                    3'd7: code = 5'd2;
                endcase
            end
        end else begin
            ill = 1'b1;
        end
        return {ill, m, code};
    endfunction

    // Transaction model: one word in flight, visible from cycle number m_due onward.
    int         cyc = 0;
    int         m_due = 0;
    logic       m_pending;
    logic [4:0] m_ctrl;
    logic       m_mc;
    logic       m_ill;
    logic       m_vis;
    logic       m_rdy;
    logic [6:0] m_dec;
    int         m_lat;

    always_comb begin
        m_vis = m_pending && (cyc >= m_due);
        m_rdy = !m_pending || (m_vis && out_ready);
        m_dec = ref_dec(alu_op, funct3, opb5, funct7b5, funct7b0);
        m_lat = m_dec[5] ? (funct3[2] ? DIV_LAT : MUL_LAT) : 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_ctrl    <= 5'd0;
            m_mc      <= 1'b0;
            m_ill     <= 1'b0;
        end else if (in_valid && m_rdy) begin
            m_pending <= 1'b1;
            m_due     <= cyc + m_lat;
            m_ctrl    <= m_dec[4:0];
            m_mc      <= m_dec[5];
            m_ill     <= m_dec[6];
        end else if (m_vis && out_ready) begin
            m_pending <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("out_valid", out_valid, m_vis);
            chk("busy", busy, m_pending && !m_vis);
            chk("in_ready", in_ready, m_rdy);
            chk("alu_control", alu_control, m_ctrl);
            chk("multicycle", multicycle, m_mc);
            chk("illegal", illegal, m_ill);
        end
    end

    // One cycle: drive inputs just after a rising edge, return just after the next one.
    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic b5, input logic f75, input logic f70,
                         input logic ordy, output logic acc);
        in_valid  = v;
        alu_op    = op;
        funct3    = f3;
        opb5      = b5;
        funct7b5  = f75;
        funct7b0  = f70;
        out_ready = ordy;
        @(negedge clk);
        acc = v && m_rdy;
        @(posedge clk);
        #1;
        $display("txn t=%0t valid=%0b op=%b f3=%b b5=%0b f7b5=%0b f7b0=%0b ordy=%0b acc=%0b ctrl=%b ov=%0b",
                 $time, v, op, f3, b5, f75, f70, ordy, acc, alu_control, out_valid);
    endtask

    task automatic idle(input logic ordy);
        logic a;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, ordy, a);
    endtask

    logic [7:0] vec [15] = '{
        8'b10_010_100, 8'b10_011_100, 8'b10_001_100, 8'b10_101_100, 8'b10_101_010,
        8'b10_110_100, 8'b10_111_100, 8'b10_000_010, 8'b01_001_000, 8'b01_101_000,
        8'b01_010_000, 8'b11_000_000, 8'b10_000_101, 8'b10_110_101, 8'b10_011_101
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic [7:0] v;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_alu_control", alu_control, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_multicycle", multicycle, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("in_ready_after_reset", in_ready, 1'b1);

        // Load/store add, one-cycle latency.
        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, a);
        chk("add_out_valid", out_valid, 1'b1);
        chk("add_ctrl", alu_control, 5'b00000);
        chk("add_illegal", illegal, 1'b0);

        // Back-to-back sub then sra with no bubble.
        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, a);
        chk("sub_ctrl", alu_control, 5'b00001);
        chk("b2b_in_ready", in_ready, 1'b1);
        drive(1'b1, 2'b10, 3'b101, 1'b1, 1'b1, 1'b0, 1'b1, a);
        chk("sra_ctrl", alu_control, 5'b01001);
        chk("sra_out_valid", out_valid, 1'b1);
        idle(1'b1);
        chk("drained_out_valid", out_valid, 1'b0);
        chk("ctrl_held_when_idle", alu_control, 5'b01001);

        // Branch sltu held while execute stalls; a competing xor must wait.
        drive(1'b1, 2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, a);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ctrl", alu_control, 5'b00110);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, a);
        end
        drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, a);
        chk("xor_ctrl", alu_control, 5'b00100);
        idle(1'b1);

        // Divide (funct3=100) issued with R-type M-ext select.
        drive(1'b1, 2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, a);
`ifdef RV_M_EXT_EN
        for (int k = 1; k <= DIV_LAT - 1; k++) begin
            chk("div_busy", busy, 1'b1);
            chk("div_in_ready", in_ready, 1'b0);
            chk("div_out_valid_low", out_valid, 1'b0);
            idle(1'b1);
        end
        chk("div_out_valid", out_valid, 1'b1);
        chk("div_ctrl", alu_control, 5'b10100);
        chk("div_multicycle", multicycle, 1'b1);
        chk("div_busy_done", busy, 1'b0);
`else
        chk("noM_out_valid", out_valid, 1'b1);
        chk("noM_ctrl", alu_control, 5'b00000);
        chk("noM_illegal", illegal, 1'b1);
        chk("noM_busy", busy, 1'b0);
`endif
        idle(1'b1);

        // Remaining encodings with random backpressure, checked by the model.
        for (int n = 0; n < 15; n++) begin
            v = vec[n];
            a = 1'b0;
            for (int t = 0; t < 24 && !a; t++) begin
                drive(1'b1, v[7:6], v[5:3], v[2], v[1], v[0], 1'($urandom_range(0, 1)), a);
            end
            chk("vec_accepted", a, 1'b1);
            repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)));
        end
        for (int t = 0; t < 20; t++) idle(1'b1);

        // Multiply in flight, reset pulled mid-operation.
        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, a);
        idle(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ctrl", alu_control, 5'd0);
        chk("midrst_multicycle", multicycle, 1'b0);
        chk("midrst_illegal", illegal, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered, handshaked successor to the single-cycle ALU decoder in the RV32 datapath; sits between the main decoder (issue side) and the ALU/execute stage.
- Maps ALUOp/funct3/op bit 5/funct7 bits onto a CTRL_W-bit ALU control word, including the full RV32I set and optional RV32M.
- For multiply/divide ops it holds the result valid low for a programmable latency, stalling issue, so execute can use iterative units.

Parameters:
- CTRL_W, 5, ALU control width; must be >= 5.
- MUL_LAT, 3, cycles from accept to out_valid for mul/mulh/mulhsu/mulhu; range 1..255.
- DIV_LAT, 8, cycles from accept to out_valid for div/divu/rem/remu; range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  issue request valid
- in_ready  out  1  stage can accept this cycle
- alu_op  in  2  ALUOp from main decoder
- funct3  in  3  instr[14:12]
- opb5  in  1  instr[5] (1 = R-type)
- funct7b5  in  1  instr[30]
- funct7b0  in  1  instr[25] (M-ext select)
- out_valid  out  1  decoded word valid
- out_ready  in  1  execute consumes word
- alu_control  out  CTRL_W  decoded ALU operation
- multicycle  out  1  word is an M-ext op
- illegal  out  1  reserved encoding decoded
- busy  out  1  latency counter running

Behaviour:
- Reset (async, rst_n=0): out_valid=0, alu_control=0, multicycle=0, illegal=0, busy=0, state=IDLE, counter=0. in_ready=1 once rst_n is released.
- Encoding, zero-extended to CTRL_W:
  - Base ops: add 00000, sub 00001, and 00010, or 00011, xor 00100, slt 00101, sltu 00110, sll 00111, srl 01000, sra 01001.
  - M-ops: 1_0_fff, where fff=funct3 (mul 10000 .. remu 10111).
- Decode (combinational, captured on accept):
  - alu_op=00: add.
  - alu_op=01 (branch): funct3 000/001 sub; 100/101 slt; 110/111 sltu; 010/011 sub with illegal=1.
  - alu_op=10, M-op when opb5 & funct7b0 (and RV_M_EXT_EN defined): 1_0_funct3.
  - alu_op=10, otherwise by funct3:
    - 000: sub if opb5 & funct7b5, else add.
    - 001 sll; 010 slt; 011 sltu; 100 xor.
    - 101: sra if funct7b5, else srl.
    - 110 or; 111 and.
  - alu_op=11: add with illegal=1.
- Accept: in_valid & in_ready at a rising edge.
- in_ready = (state==IDLE) | (state==VALID & out_ready).
- State IDLE:
  - Accept of a base op -> VALID; out_valid=1 on the next cycle (1-cycle latency).
  - Accept of an M-op with LAT>1 -> WAIT; counter=LAT-1; busy=1; out_valid=0.
  - Accept of an M-op with LAT==1 -> VALID, same as a base op.
- State WAIT:
  - counter decrements each cycle.
  - When counter==1 and decrements -> VALID (out_valid rises exactly LAT cycles after the accept edge); busy=0.
  - in_ready=0 throughout.
- State VALID:
  - Output registers are held stable while out_ready=0.
  - out_ready=1 with no new accept -> IDLE; out_valid=0.
  - out_ready=1 with a simultaneous accept -> new word replaces the old one (back-to-back, no bubble) for base ops, or WAIT for an M-op.
- alu_control, multicycle and illegal change only on accept; they keep their last value when out_valid=0.
- Reset asserted mid-WAIT or mid-VALID: immediate return to reset values; the pending word is discarded.
- Counter width: 8 bits. Latency parameters above 255 are illegal; a simulation-only $error fires at elaboration.

Optional Feature:
- RV_M_EXT_EN defined: M-ops are decoded as above, and multicycle/busy behave as specified.
- RV_M_EXT_EN undefined:
  - opb5 & funct7b0 with alu_op=10 decodes as add with illegal=1, 1-cycle latency.
  - multicycle and busy are tied 0; the WAIT state and counter are not built.

Test Plan:
- Reset, then alu_op=00, in_valid=1, out_ready=1 -> next cycle: out_valid=1, alu_control=00000, illegal=0.
- alu_op=10, funct3=000, opb5=1, funct7b5=1, issued back-to-back with funct3=101, funct7b5=1, out_ready=1 -> alu_control 00001 then 01001 on consecutive cycles, in_ready stays 1.
- alu_op=01, funct3=110 with out_ready=0 for 3 cycles -> alu_control=00110 held stable, in_ready=0 until out_ready=1.
- With RV_M_EXT_EN: alu_op=10, opb5=1, funct7b0=1, funct3=100, DIV_LAT=8 -> busy=1 and in_ready=0 for cycles 1..7; out_valid=1 at cycle 8 with alu_control=10100, multicycle=1.
- Without RV_M_EXT_EN: the same stimulus -> out_valid next cycle, alu_control=00000, illegal=1, busy=0.
- With MUL_LAT=3: accept mul, drop rst_n at cycle 2 -> all outputs 0 immediately; after release, in_ready=1 and out_valid=0.
